program_counter_ras: RTL and testbench
======================================

Name: program_counter_ras

Overview:
- Next-generation program counter. It adds a return-address stack (RAS) to the existing increment / jump / conditional-branch behaviour, so the block supports CALL and RET.
- It also adds a pipeline stall and optional PC-relative branch targets.
- It sits in the fetch stage. It drives the instruction address and takes control strobes from the decoder and flags from the register file status register.

Parameters:
- I_ADDR_W, 12, instruction address width; PC wraps modulo 2^I_ADDR_W.
- DATA_W, 8, status register width.
- RAS_DEPTH, 4, number of return-address entries; must be a power of two and at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst  in  1  Reset, synchronous, active-high.
- stall  in  1  When high, hold all state; all other strobes are ignored.
- imar  in  I_ADDR_W  Register-sourced target address.
- address_immediate  in  I_ADDR_W  Immediate target, or signed offset when relative=1.
- immediate_select  in  1  1: target from address_immediate; 0: target from imar.
- relative  in  1  Applies to the immediate target only: target = pc + address_immediate, modulo 2^I_ADDR_W.
- jump_branch_select  in  1  Request a jump or branch.
- unconditional_branch  in  1  1: jump is always taken; 0: taken only when the condition holds.
- branch_condition  in  3  branch_condition_e selector.
- status_register  in  DATA_W  Flags at ZERO_FLAG / POSITIVE_FLAG / CARRY_FLAG / OVERFLOW_FLAG.
- call  in  1  Unconditional jump to target; pushes pc+1.
- ret  in  1  Pops the top of the RAS into pc.
- pc  out  I_ADDR_W  Current PC (registered).
- ras_count  out  $clog2(RAS_DEPTH)+1  Number of valid RAS entries.
- ras_overflow  out  1  Sticky; set by a call while the RAS is full.
- ras_underflow  out  1  Sticky; set by a ret while the RAS is empty.

Behaviour:
- Reset (rst=1 at a rising edge, takes priority over everything, including stall):
  - pc=RESET_PC, ras_count=0, RAS pointer=0.
  - ras_overflow=0, ras_underflow=0.
  - RAS contents are don't-care.
- Stall: when stall=1 and rst=0, pc, the RAS, the count and the flags all hold.
- Priority when not stalled: ret > call > jump_branch_select > increment. Lower-priority strobes asserted in the same cycle are ignored.
- Target computation:
  - immediate_select=0: target = imar (relative ignored).
  - immediate_select=1, relative=0: target = address_immediate.
  - immediate_select=1, relative=1: target = (pc + address_immediate) modulo 2^I_ADDR_W; the offset is two's complement, I_ADDR_W bits.
- Condition evaluation: taken = f(branch_condition, status_register), using the branch_condition_e truth table from program_counter_pkg shared with program_counter. Flag bits other than the four named flags are ignored.
- Increment: pc <= pc+1. 12'hFFF wraps to 12'h000.
- Jump (jump_branch_select=1):
  - pc <= target if unconditional_branch=1, or if taken=1.
  - Otherwise pc <= pc+1.
- Call:
  - Push (pc+1) modulo 2^I_ADDR_W, then pc <= target. The branch condition is not consulted.
  - Not full: ras_count increments.
  - Full (ras_count==RAS_DEPTH): the push still happens and overwrites the oldest entry (circular buffer). ras_count stays at RAS_DEPTH and ras_overflow <= 1.
- Ret:
  - ras_count>0: pc <= top entry; ras_count decrements.
  - ras_count==0: pc <= pc+1, pointer unchanged, ras_underflow <= 1.
- Storage: the RAS is a circular buffer with a log2(RAS_DEPTH) top pointer. Push writes at top+1 and advances the pointer; pop reads at top and retreats the pointer.
- Sticky flags clear only on rst.
- Latency: every update is visible on pc one cycle after the sampling edge. There is no combinational path from inputs to pc.
- Reset during a call/ret sequence discards all stack state; a subsequent ret underflows.

Test Plan:
- Reset, then 10 non-stalled cycles with all strobes low -> pc = 000..00A; ras_count=0; both flags 0.
- pc=00A, call with immediate 100 -> pc=100, ras_count=1. Then call with imar=200 -> pc=200, ras_count=2. Then ret -> pc=101. Then ret -> pc=00B, ras_count=0.
- Five calls with RAS_DEPTH=4, targets 010/020/030/040/050, starting at pc=000 -> ras_overflow=1, ras_count=4. Four rets -> pc = 041, 031, 021, 011. The fifth ret -> pc=012, ras_underflow=1.
- Relative branch: pc=1F0, immediate_select=1, relative=1, offset FF0 (-16) -> pc=1E0. With pc=FFF and offset 002 -> pc=001 (wrap).
- Conditional branch:
  - COND_ZERO with ZERO_FLAG=1, target 300 -> pc=300.
  - COND_ZERO with ZERO_FLAG=0 -> pc=301.
  - Repeat for all 8 conditions: each taken -> pc=target, each not taken -> pc=pc+1.
- Stall asserted with call=1 for 3 cycles -> pc and ras_count unchanged. With stall=1 and rst=1 -> pc=RESET_PC. Simultaneous ret+call with ras_count=1 -> ret wins, ras_count=0.

Source files
------------

// File: rtl/program_counter_ras.sv
// Fetch-stage program counter with jump/branch, PC-relative targets, stall and a
// circular return-address stack for CALL/RET.

package program_counter_pkg;

  localparam int ZERO_FLAG     = 0;
  localparam int POSITIVE_FLAG = 1;
  localparam int CARRY_FLAG    = 2;
  localparam int OVERFLOW_FLAG = 3;

  typedef enum logic [2:0] {
    COND_ZERO         = 3'd0,
    COND_NOT_ZERO     = 3'd1,
    COND_POSITIVE     = 3'd2,
    COND_NOT_POSITIVE = 3'd3,
    COND_CARRY        = 3'd4,
    COND_NOT_CARRY    = 3'd5,
    COND_OVERFLOW     = 3'd6,
    COND_NOT_OVERFLOW = 3'd7
  } branch_condition_e;

endpackage

module program_counter_ras
  import program_counter_pkg::*;
#(
  parameter int                    I_ADDR_W  = 12,
  parameter int                    DATA_W    = 8,
  parameter int                    RAS_DEPTH = 4,
  parameter logic [I_ADDR_W-1:0]   RESET_PC  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [I_ADDR_W-1:0]           imar,
  input  logic [I_ADDR_W-1:0]           address_immediate,
  input  logic                          immediate_select,
  input  logic                          relative,
  input  logic                          jump_branch_select,
  input  logic                          unconditional_branch,
  input  logic [2:0]                    branch_condition,
  input  logic [DATA_W-1:0]             status_register,
  input  logic                          call,
  input  logic                          ret,
  output logic [I_ADDR_W-1:0]           pc,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_overflow,
  output logic                          ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("program_counter_ras: RAS_DEPTH must be a power of two and at least 2");
  end

  logic [I_ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    top;
  logic [PTR_W-1:0]    push_ptr;
  logic [I_ADDR_W-1:0] pc_plus_one;
  logic [I_ADDR_W-1:0] target;
  logic                taken;
  logic                ras_full;
  logic                ras_empty;
  logic                push_en;
  branch_condition_e   cond;

  // Only the four named flags matter; the remaining status bits are deliberately dropped.
  logic unused_status;
  assign unused_status = ^status_register;

  assign pc_plus_one = pc + I_ADDR_W'(1);
  assign push_ptr    = top + PTR_W'(1);
  assign ras_full    = (ras_count == FULL_COUNT);
  assign ras_empty   = (ras_count == '0);
  assign cond        = branch_condition_e'(branch_condition);
  assign push_en     = !rst && !stall && !ret && call;

  // Relative offsets are two's complement, so a plain modular add covers both directions.
  always_comb begin
    target = imar;
    if (immediate_select) begin
      target = relative ? (pc + address_immediate) : address_immediate;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ZERO:         taken =  status_register[ZERO_FLAG];
      COND_NOT_ZERO:     taken = !status_register[ZERO_FLAG];
      COND_POSITIVE:     taken =  status_register[POSITIVE_FLAG];
      COND_NOT_POSITIVE: taken = !status_register[POSITIVE_FLAG];
      COND_CARRY:        taken =  status_register[CARRY_FLAG];
      COND_NOT_CARRY:    taken = !status_register[CARRY_FLAG];
      COND_OVERFLOW:     taken =  status_register[OVERFLOW_FLAG];
      COND_NOT_OVERFLOW: taken = !status_register[OVERFLOW_FLAG];
      default:           taken = 1'b0;
    endcase
  end

  // Stack storage needs no reset; a full push lands on the oldest entry.
  always_ff @(posedge clk) begin
    if (push_en) begin
      ras_mem[push_ptr] <= pc_plus_one;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      top           <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (!stall) begin
      if (ret) begin
        if (!ras_empty) begin
          pc        <= ras_mem[top];
          top       <= top - PTR_W'(1);
          ras_count <= ras_count - CNT_W'(1);
        end else begin
          pc            <= pc_plus_one;
          ras_underflow <= 1'b1;
        end
      end else if (call) begin
        pc  <= target;
        top <= push_ptr;
        if (ras_full) begin
          ras_overflow <= 1'b1;
        end else begin
          ras_count <= ras_count + CNT_W'(1);
        end
      end else if (jump_branch_select && (unconditional_branch || taken)) begin
        pc <= target;
      end else begin
        pc <= pc_plus_one;
      end
    end
  end

endmodule

// File: tb/tb_program_counter_ras.sv
// Scoreboard bench for program_counter_ras: a queue-based stack model predicts every
// cycle, a negedge monitor compares, plus directed checks of the documented scenarios.

module tb_program_counter_ras;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam logic [AW-1:0] RST_PC = 12'h000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          stall;
  logic [AW-1:0] imar;
  logic [AW-1:0] address_immediate;
  logic          immediate_select;
  logic          relative;
  logic          jump_branch_select;
  logic          unconditional_branch;
  logic [2:0]    branch_condition;
  logic [DW-1:0] status_register;
  logic          call;
  logic          ret;
  logic [AW-1:0] pc;
  logic [CW-1:0] ras_count;
  logic          ras_overflow;
  logic          ras_underflow;

  program_counter_ras #(
    .I_ADDR_W (AW),
    .DATA_W   (DW),
    .RAS_DEPTH(DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .imar                (imar),
    .address_immediate   (address_immediate),
    .immediate_select    (immediate_select),
    .relative            (relative),
    .jump_branch_select  (jump_branch_select),
    .unconditional_branch(unconditional_branch),
    .branch_condition    (branch_condition),
    .status_register     (status_register),
    .call                (call),
    .ret                 (ret),
    .pc                  (pc),
    .ras_count           (ras_count),
    .ras_overflow        (ras_overflow),
    .ras_underflow       (ras_underflow)
  );

  typedef struct {
    string         tag;
    logic [AW-1:0] pc;
    logic [CW-1:0] cnt;
    logic          ov;
    logic          un;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the stack is a bounded queue, newest at the back.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stack[$];
  logic          m_ov;
  logic          m_un;

  int total = 0;
  int bad   = 0;

  // Condition code -> (flag bit, inverted) : Z, !Z, P, !P, C, !C, V, !V
  int flag_of [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  bit inv_of  [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

  function automatic bit condTaken(input int c, input logic [DW-1:0] sr);
    return bit'(sr[flag_of[c]]) ^ inv_of[c];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic modelStep();
    logic [AW-1:0] tgt;
    if (rst) begin
      m_pc = RST_PC;
      m_stack.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else if (!stall) begin
      if (!immediate_select)  tgt = imar;
      else if (relative)      tgt = AW'(m_pc + address_immediate);
      else                    tgt = address_immediate;
      if (ret) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin
          m_pc = AW'(m_pc + 1);
          m_un = 1'b1;
        end
      end else if (call) begin
        m_stack.push_back(AW'(m_pc + 1));
        if (m_stack.size() > DEPTH) begin
          void'(m_stack.pop_front());
          m_ov = 1'b1;
        end
        m_pc = tgt;
      end else if (jump_branch_select && (unconditional_branch || condTaken(int'(branch_condition), status_register))) begin
        m_pc = tgt;
      end else begin
        m_pc = AW'(m_pc + 1);
      end
    end
  endtask

  task automatic applyStimulus(input string tag);
    exp_t e;
    modelStep();
    e.tag = tag;
    e.pc  = m_pc;
    e.cnt = CW'(m_stack.size());
    e.ov  = m_ov;
    e.un  = m_un;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic setIdle();
    rst = 1'b0; stall = 1'b0; imar = '0; address_immediate = '0;
    immediate_select = 1'b0; relative = 1'b0; jump_branch_select = 1'b0;
    unconditional_branch = 1'b0; branch_condition = '0; status_register = '0;
    call = 1'b0; ret = 1'b0;
  endtask

  task automatic doReset();
    setIdle();
    rst = 1'b1;
    applyStimulus("reset");
    setIdle();
  endtask

  task automatic jumpTo(input logic [AW-1:0] a);
    setIdle();
    jump_branch_select = 1'b1; unconditional_branch = 1'b1;
    immediate_select = 1'b1; address_immediate = a;
    applyStimulus("jump");
    setIdle();
  endtask

  task automatic callImm(input logic [AW-1:0] a);
    setIdle();
    call = 1'b1; immediate_select = 1'b1; address_immediate = a;
    applyStimulus("call");
    setIdle();
  endtask

  task automatic doRet();
    setIdle();
    ret = 1'b1;
    applyStimulus("ret");
    setIdle();
  endtask

  // Monitor: the pc is always presented, so every cycle with a pending prediction is checked.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput({e.tag, ".pc"},        32'(pc),            32'(e.pc));
        checkOutput({e.tag, ".ras_count"}, 32'(ras_count),     32'(e.cnt));
        checkOutput({e.tag, ".overflow"},  32'(ras_overflow),  32'(e.ov));
        checkOutput({e.tag, ".underflow"}, 32'(ras_underflow), 32'(e.un));
      end
    end
  end

  initial begin
    logic [AW-1:0] want;
    m_pc = RST_PC; m_ov = 1'b0; m_un = 1'b0;
    setIdle();
    $display("[TB] start");

    doReset();
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus("incr");
    checkOutput("plan_pc_00A", 32'(pc), 32'h00A);
    checkOutput("plan_cnt_0", 32'(ras_count), 32'd0);
    checkOutput("plan_flags_0", 32'({ras_overflow, ras_underflow}), 32'd0);

    callImm(12'h100);
    checkOutput("call_pc_100", 32'(pc), 32'h100);
    setIdle(); call = 1'b1; imar = 12'h200;
    applyStimulus("call_imar");
    setIdle();
    checkOutput("call_pc_200", 32'(pc), 32'h200);
    checkOutput("call_cnt_2", 32'(ras_count), 32'd2);
    doRet();
    checkOutput("ret_pc_101", 32'(pc), 32'h101);
    doRet();
    checkOutput("ret_pc_00B", 32'(pc), 32'h00B);
    checkOutput("ret_cnt_0", 32'(ras_count), 32'd0);

    doReset();
    for (int i = 1; i <= 5; i++) callImm(AW'(i * 16));
    checkOutput("ovf_flag", 32'(ras_overflow), 32'd1);
    checkOutput("ovf_cnt_4", 32'(ras_count), 32'd4);
    for (int i = 4; i >= 1; i--) begin
      doRet();
      checkOutput("ovf_ret_pc", 32'(pc), 32'(i * 16 + 1));
    end
    doRet();
    checkOutput("udf_pc_012", 32'(pc), 32'h012);
    checkOutput("udf_flag", 32'(ras_underflow), 32'd1);

    jumpTo(12'h1F0);
    setIdle(); jump_branch_select = 1'b1; unconditional_branch = 1'b1;
    immediate_select = 1'b1; relative = 1'b1; address_immediate = 12'hFF0;
    applyStimulus("rel_back");
    checkOutput("rel_pc_1E0", 32'(pc), 32'h1E0);
    jumpTo(12'hFFF);
    setIdle(); jump_branch_select = 1'b1; unconditional_branch = 1'b1;
    immediate_select = 1'b1; relative = 1'b1; address_immediate = 12'h002;
    applyStimulus("rel_wrap");
    checkOutput("rel_pc_001", 32'(pc), 32'h001);
    setIdle();

    for (int c = 0; c < 8; c++) begin
      for (int t = 0; t < 2; t++) begin
        jumpTo(12'h300);
        jump_branch_select = 1'b1; branch_condition = 3'(c);
        immediate_select = 1'b1; address_immediate = 12'h300;
        status_register = {4'($urandom()), (t == 1) ? 4'hF : 4'h0};
        applyStimulus($sformatf("cond%0d_%0d", c, t));
        setIdle();
        want = (((t == 1) ? 1 : 0) ^ (c % 2)) != 0 ? 12'h300 : 12'h301;
        checkOutput($sformatf("cond%0d_flags%0d_pc", c, t), 32'(pc), 32'(want));
      end
    end

    doReset();
    callImm(12'h123);
    setIdle(); stall = 1'b1; call = 1'b1; immediate_select = 1'b1; address_immediate = 12'h777;
    for (int i = 0; i < 3; i++) applyStimulus("stall_call");
    checkOutput("stall_pc_hold", 32'(pc), 32'h123);
    checkOutput("stall_cnt_hold", 32'(ras_count), 32'd1);
    rst = 1'b1;
    applyStimulus("stall_rst");
    setIdle();
    checkOutput("stall_rst_pc", 32'(pc), 32'(RST_PC));
    callImm(12'h050);
    ret = 1'b1; call = 1'b1; immediate_select = 1'b1; address_immediate = 12'h444;
    applyStimulus("ret_beats_call");
    setIdle();
    checkOutput("ret_call_pc_001", 32'(pc), 32'h001);
    checkOutput("ret_call_cnt_0", 32'(ras_count), 32'd0);

    for (int i = 0; i < 400; i++) begin
      rst                  = ($urandom_range(0, 40) == 0);
      stall                = ($urandom_range(0, 4) == 0);
      imar                 = AW'($urandom());
      address_immediate    = AW'($urandom());
      immediate_select     = 1'($urandom());
      relative             = 1'($urandom());
      jump_branch_select   = 1'($urandom());
      unconditional_branch = 1'($urandom());
      branch_condition     = 3'($urandom());
      status_register      = DW'($urandom());
      call                 = ($urandom_range(0, 3) == 0);
      ret                  = ($urandom_range(0, 3) == 0);
      applyStimulus("random");
    end
    setIdle();

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
